// File: rtl/mult_sched.sv
// mult_sched: round-robin scheduler that hands one requester at a time to a
// shared shift-multiplier datapath, waits for its completion (or a timeout)
// and returns the product to the requester that was granted.
module mult_sched #(
  parameter int WIDTH   = 8,
  parameter int N       = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         req,
  input  logic [N*WIDTH-1:0]   op_a,
  input  logic [N*WIDTH-1:0]   op_b,
  output logic [N-1:0]         grant,
  output logic [N-1:0]         res_valid,
  output logic [2*WIDTH-1:0]   result,
  output logic                 err,
  output logic                 busy,
  output logic                 dp_start,
  output logic [WIDTH-1:0]     dp_a,
  output logic [WIDTH-1:0]     dp_b,
  input  logic                 dp_done,
  input  logic [2*WIDTH-1:0]   dp_result
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic [4:0] S_IDLE  = 5'b00001;
  localparam logic [4:0] S_LATCH = 5'b00010;
  localparam logic [4:0] S_START = 5'b00100;
  localparam logic [4:0] S_WAIT  = 5'b01000;
  localparam logic [4:0] S_RESP  = 5'b10000;

  logic [4:0]         state_q, state_d;
  logic [IW-1:0]      ptr_q, ptr_d;
  logic [IW-1:0]      winner_q, winner_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   opA_q, opA_d;
  logic [WIDTH-1:0]   opB_q, opB_d;
  logic [2*WIDTH-1:0] resultReg_q, resultReg_d;
  logic               errReg_q, errReg_d;

  logic [IW-1:0]      arbWinner;
  logic               arbFound;
  logic [IW:0]        arbSum;
  logic [WIDTH-1:0]   selA, selB;
  logic [N-1:0]       winnerOneHot;

  // Round-robin search: first requester with req set, starting at ptr and wrapping.
  always_comb begin
    arbWinner = ptr_q;
    arbFound  = 1'b0;
    arbSum    = '0;
    for (int k = 0; k < N; k++) begin
      arbSum = {1'b0, ptr_q} + (IW+1)'(k);
      if (arbSum >= (IW+1)'(N)) begin
        arbSum = arbSum - (IW+1)'(N);
      end
      if (!arbFound && req[arbSum[IW-1:0]]) begin
        arbFound  = 1'b1;
        arbWinner = arbSum[IW-1:0];
      end
    end
  end

  // Operand mux selecting the stored winner's slice of the packed operand buses.
  always_comb begin
    selA = '0;
    selB = '0;
    for (int i = 0; i < N; i++) begin
      if (winner_q == IW'(i)) begin
        selA = op_a[i*WIDTH +: WIDTH];
        selB = op_b[i*WIDTH +: WIDTH];
      end
    end
  end

  // Next-state and datapath register updates for the five-state schedule.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    winner_d    = winner_q;
    cnt_d       = cnt_q;
    opA_d       = opA_q;
    opB_d       = opB_q;
    resultReg_d = resultReg_q;
    errReg_d    = errReg_q;
    case (state_q)
      S_IDLE: begin
        if (arbFound) begin
          winner_d = arbWinner;
          state_d  = S_LATCH;
        end
      end
      S_LATCH: begin
        opA_d   = selA;
        opB_d   = selB;
        ptr_d   = (winner_q == IW'(N - 1)) ? '0 : winner_q + IW'(1);
        state_d = S_START;
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (dp_done) begin
          resultReg_d = dp_result;
          errReg_d    = 1'b0;
          state_d     = S_RESP;
        end else if (cnt_q == CNT_LAST) begin
          resultReg_d = '0;
          errReg_d    = 1'b1;
          state_d     = S_RESP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      winner_q    <= '0;
      cnt_q       <= '0;
      opA_q       <= '0;
      opB_q       <= '0;
      resultReg_q <= '0;
      errReg_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      winner_q    <= winner_d;
      cnt_q       <= cnt_d;
      opA_q       <= opA_d;
      opB_q       <= opB_d;
      resultReg_q <= resultReg_d;
      errReg_q    <= errReg_d;
    end
  end

  // Moore outputs decoded from the state register only.
  always_comb begin
    winnerOneHot = {{(N-1){1'b0}}, 1'b1} << winner_q;
    grant        = (state_q == S_LATCH) ? winnerOneHot : '0;
    res_valid    = (state_q == S_RESP)  ? winnerOneHot : '0;
    result       = (state_q == S_RESP)  ? resultReg_q  : '0;
    err          = (state_q == S_RESP)  && errReg_q;
    busy         = (state_q != S_IDLE);
    dp_start     = (state_q == S_START);
    dp_a         = opA_q;
    dp_b         = opB_q;
  end

endmodule

// File: tb/tb_mult_sched.sv
// Directed testbench for mult_sched (N=4, WIDTH=8, TIMEOUT=8).
module tb_mult_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  req = '0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic [3:0]  grant;
  logic [3:0]  res_valid;
  logic [15:0] result;
  logic        err;
  logic        busy;
  logic        dp_start;
  logic [7:0]  dp_a;
  logic [7:0]  dp_b;
  logic        dp_done = 1'b0;
  logic [15:0] dp_result = '0;

  int checks = 0;
  int failures = 0;

  logic [3:0]  rrGrant [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [7:0]  rrA     [5] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd10};
  logic [7:0]  rrB     [5] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd1};
  logic [15:0] rrP     [5] = '{16'd10, 16'd40, 16'd90, 16'd160, 16'd10};

  mult_sched #(.WIDTH(8), .N(4), .TIMEOUT(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .op_a      (op_a),
    .op_b      (op_b),
    .grant     (grant),
    .res_valid (res_valid),
    .result    (result),
    .err       (err),
    .busy      (busy),
    .dp_start  (dp_start),
    .dp_a      (dp_a),
    .dp_b      (dp_b),
    .dp_done   (dp_done),
    .dp_result (dp_result)
  );

  // Free-running 10ns clock.
  always #5 clk = ~clk;

  // Hard stop in case something hangs beyond every bounded wait.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] pack4(input logic [7:0] a3, a2, a1, a0);
    return {a3, a2, a1, a0};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [31:0] a, input logic [31:0] b);
    req  = r;
    op_a = a;
    op_b = b;
  endtask

  task automatic applyReset();
    rst     = 1'b0;
    req     = '0;
    dp_done = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst.grant", grant, 0);
    checkOutput("rst.res_valid", res_valid, 0);
    checkOutput("rst.dp_start", dp_start, 0);
    checkOutput("rst.busy", busy, 0);
    checkOutput("rst.err", err, 0);
    checkOutput("rst.result", result, 0);
    checkOutput("rst.dp_a", dp_a, 0);
    checkOutput("rst.dp_b", dp_b, 0);
    rst = 1'b1;
  endtask

  // One full transaction; returns at the negedge inside the response cycle.
  task automatic runTxn(input string tag, input logic [3:0] expGrant, input int expWait,
                        input logic [7:0] expA, input logic [7:0] expB, input int doneAfter,
                        input logic [15:0] dpRes, input logic [15:0] expRes, input logic expErr,
                        input int expDelay, input logic dropReq);
    int w;
    int k;
    w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (grant == '0 && w < 20);
    checkOutput({tag, ".grant"}, grant, expGrant);
    checkOutput({tag, ".grantWait"}, w, expWait);
    checkOutput({tag, ".noEarlyValid"}, res_valid, 0);
    if (dropReq) req = '0;
    @(negedge clk);
    dp_done = 1'b0;
    checkOutput({tag, ".dp_start"}, dp_start, 1);
    checkOutput({tag, ".grantPulse"}, grant, 0);
    checkOutput({tag, ".dp_a"}, dp_a, expA);
    checkOutput({tag, ".dp_b"}, dp_b, expB);
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (res_valid == '0) begin
        dp_done   = (k == doneAfter);
        dp_result = dpRes;
      end
    end while (res_valid == '0 && k < 40);
    dp_done = 1'b0;
    checkOutput({tag, ".res_valid"}, res_valid, expGrant);
    checkOutput({tag, ".result"}, result, expRes);
    checkOutput({tag, ".err"}, err, expErr);
    checkOutput({tag, ".respDelay"}, k, expDelay);
  endtask

  initial begin
    $display("[TB] start");
    applyReset();

    // Single request from requester 2.
    applyStimulus(4'b0100, pack4(8'd0, 8'd13, 8'd0, 8'd0), pack4(8'd0, 8'd11, 8'd0, 8'd0));
    runTxn("single", 4'b0100, 1, 8'd13, 8'd11, 3, 16'd143, 16'd143, 1'b0, 4, 1'b0);

    // Request dropped during the grant cycle still completes (ptr now 3 -> winner 0).
    applyStimulus(4'b0001, pack4(8'd40, 8'd30, 8'd20, 8'd10), pack4(8'd4, 8'd3, 8'd2, 8'd1));
    runTxn("dropReq", 4'b0001, 2, 8'd10, 8'd1, 1, 16'd10, 16'd10, 1'b0, 2, 1'b1);

    // Stray completion while idle is ignored.
    req     = '0;
    dp_done = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("strayIdle.busy", busy, 0);
      checkOutput("strayIdle.res_valid", res_valid, 0);
    end

    // Stray completion through the grant cycle is ignored (ptr 1 -> winner 2).
    req = 4'b0100;
    runTxn("strayLatch", 4'b0100, 1, 8'd30, 8'd3, 2, 16'd90, 16'd90, 1'b0, 3, 1'b0);
    req = '0;

    // Round-robin with every requester held high.
    applyReset();
    applyStimulus(4'b1111, pack4(8'd40, 8'd30, 8'd20, 8'd10), pack4(8'd4, 8'd3, 8'd2, 8'd1));
    for (int i = 0; i < 5; i++) begin
      runTxn("rr", rrGrant[i], (i == 0) ? 1 : 2, rrA[i], rrB[i], 2, rrP[i], rrP[i], 1'b0, 3, 1'b0);
    end

    // Timeout: no completion, ptr 1 -> winner 1.
    req = 4'b0010;
    runTxn("timeout", 4'b0010, 2, 8'd20, 8'd2, 0, 16'hBEEF, 16'h0000, 1'b1, 9, 1'b0);

    // Completion on the last wait cycle beats the timeout.
    req = 4'b1000;
    runTxn("simul", 4'b1000, 2, 8'd40, 8'd4, 8, 16'h00FF, 16'h00FF, 1'b0, 9, 1'b0);
    req = '0;

    // Asynchronous reset in the middle of a wait.
    applyReset();
    req = 4'b1010;
    begin
      int w;
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (grant == '0 && w < 20);
      checkOutput("midReset.grant", grant, 4'b0010);
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checkOutput("midReset.busy", busy, 0);
    checkOutput("midReset.res_valid", res_valid, 0);
    @(negedge clk);
    checkOutput("midReset.noValid", res_valid, 0);
    rst = 1'b1;
    runTxn("postReset", 4'b0010, 1, 8'd20, 8'd2, 3, 16'd40, 16'd40, 1'b0, 4, 1'b0);
    req = '0;
    @(negedge clk);
    checkOutput("final.result", result, 0);
    checkOutput("final.busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
